// File: rtl/demux_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module : demux_dispatch_pkg
// Brief  : Shared types and constants for the demux_dispatch serializer.
// Rev    : 1.0  initial release
// ============================================================================
package demux_dispatch_pkg;

    localparam int LANE_CNT    = 4;
    localparam int LANE_W      = $clog2(LANE_CNT);
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_GAP_CYC = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage : demux_dispatch_pkg
`default_nettype wire

// File: rtl/rr_lane_ctr.sv
`default_nettype none
// ============================================================================
// Module : rr_lane_ctr
// Brief  : Round-robin lane counter, advances by one per strobe, wraps 3->0.
// Rev    : 1.0  initial release
// ============================================================================
module rr_lane_ctr
    import demux_dispatch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    output logic [LANE_W-1:0] lane_o
);

    logic [LANE_W-1:0] lane_q;

    // LANE_CNT is a power of two, so natural overflow gives the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
        end else if (inc_i) begin
            lane_q <= lane_q + LANE_W'(1);
        end
    end

    assign lane_o = lane_q;

endmodule : rr_lane_ctr
`default_nettype wire

// File: rtl/demux_dispatch.sv
`default_nettype none
// ============================================================================
// Module : demux_dispatch
// Brief  : Serializes bytes LSB-first onto the 1:4 demux with round-robin
//          lane select. Define DEMUX_DISPATCH_PARITY_EN to append even parity.
// Rev    : 1.0  initial release
// ============================================================================
module demux_dispatch
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              en,
    output logic              i,
    output logic              s0,
    output logic              s1,
    output logic              frame,
    output logic              frame_done
);

`ifdef DEMUX_DISPATCH_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam int               CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] PEN_IDX  = CNT_W'(FRAME_LEN - 2);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYC - 1);

    state_t                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       bit_q,   bit_d;
    logic [3:0]             gap_q,   gap_d;
    logic [LANE_W-1:0]      sel_q,   sel_d;
    logic                   i_q,     i_d;
    logic                   frame_q, frame_d;
    logic                   done_q,  done_d;

    logic [FRAME_LEN-1:0]   w_load;
    logic [LANE_W-1:0]      w_lane;
    logic                   w_lane_inc;

`ifdef DEMUX_DISPATCH_PARITY_EN
    assign w_load = {^din, din};
`else
    assign w_load = din;
`endif

    rr_lane_ctr u_lane_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (w_lane_inc),
        .lane_o (w_lane)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        sel_d      = sel_q;
        i_d        = i_q;
        frame_d    = frame_q;
        done_d     = 1'b0;
        w_lane_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    shreg_d = w_load;
                    sel_d   = w_lane;
                    bit_d   = '0;
                    i_d     = w_load[0];
                    frame_d = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The outputs are registered, so they are computed one edge
                // ahead: frame_done is raised on the edge that enters the last bit.
                if (en) begin
                    if (bit_q == LAST_IDX) begin
                        i_d     = 1'b0;
                        frame_d = 1'b0;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + CNT_W'(1);
                        i_d     = shreg_q[1];
                        done_d  = (bit_q == PEN_IDX);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    w_lane_inc = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                i_d     = 1'b0;
                frame_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sel_q   <= '0;
            i_q     <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            i_q     <= i_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign din_ready  = (state_q == ST_IDLE);
    assign i          = i_q;
    assign s0         = sel_q[0];
    assign s1         = sel_q[1];
    assign frame      = frame_q;
    assign frame_done = done_q;

endmodule : demux_dispatch
`default_nettype wire

// File: tb/tb_demux_dispatch.sv
`default_nettype none
// ============================================================================
// Module : tb_demux_dispatch
// Brief  : Scoreboard bench for demux_dispatch (directed byte vectors).
// Rev    : 1.0  initial release
// ============================================================================
module tb_demux_dispatch;

    localparam int DW  = 8;
    localparam int GAP = 1;
`ifdef DEMUX_DISPATCH_PARITY_EN
    localparam int FL  = DW + 1;
`else
    localparam int FL  = DW;
`endif
    localparam int P   = FL + GAP + 1;

    typedef struct packed {
        logic       bitv;
        logic [1:0] lane;
        logic       done;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          en;
    logic          ser;
    logic          s0;
    logic          s1;
    logic          frame;
    logic          frame_done;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    demux_dispatch #(.DATA_W(DW), .GAP_CYC(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .en         (en),
        .i          (ser),
        .s0         (s0),
        .s1         (s1),
        .frame      (frame),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every framed cycle pops one expected bit
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (frame) begin
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL frame_unexpected got i=%0b sel=%0d done=%0b, required no frame",
                             ser, {s1, s0}, frame_done);
                end else begin
                    mon_e = q.pop_front();
                    if ({ser, s1, s0, frame_done} !== {mon_e.bitv, mon_e.lane, mon_e.done}) begin
                        failures++;
                        $display("FAIL frame_bit got i=%0b sel=%0d done=%0b, required i=%0b sel=%0d done=%0b",
                                 ser, {s1, s0}, frame_done, mon_e.bitv, mon_e.lane, mon_e.done);
                    end
                end
            end else if (ser !== 1'b0 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL idle_out got i=%0b done=%0b, required 0 0", ser, frame_done);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_frame(input logic [7:0] b, input logic [1:0] lane,
                              input int stall_pos, input int stall_n);
        logic [8:0] bits;
        exp_t       e;
        int         reps;
        bits = {^b, b};
        for (int k = 0; k < FL; k++) begin
            reps = (k == stall_pos) ? stall_n + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                e.bitv = bits[k];
                e.lane = lane;
                e.done = (k == FL - 1) && (r == reps - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (din_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("ready_timeout", 0, 1);
    endtask

    // Present one byte for exactly one accepting edge; returns in cycle T+1
    task automatic send(input logic [7:0] b, input logic [1:0] lane);
        int n;
        wait_ready(n);
        din       = b;
        din_valid = 1'b1;
        push_frame(b, lane, -1, 0);
        step();
        din_valid = 1'b0;
        din       = 8'h5A;
    endtask

    initial begin
        int n;
        logic [7:0] v;
        logic [1:0] lane;
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        en        = 1'b1;
        repeat (3) step();
        chk("reset_outputs", int'({ser, s0, s1, frame, frame_done}), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", int'(din_ready), 1);
        step();

        // A5 on lane 0, then ready latency after acceptance
        send(8'hA5, 2'd0);
        wait_ready(n);
        chk("ready_latency", n, FL + GAP);

        // Realign the lane counter, then rotate through all four lanes
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        send(8'h01, 2'd0);
        send(8'h02, 2'd1);
        send(8'h04, 2'd2);
        send(8'h08, 2'd3);
        send(8'h10, 2'd0);

        // Stall three cycles while bit 4 of F0 is on the line
        wait_ready(n);
        din       = 8'hF0;
        din_valid = 1'b1;
        push_frame(8'hF0, 2'd1, 4, 3);
        step();
        din_valid = 1'b0;
        repeat (4) step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        wait_ready(n);
        chk("stall_latency", n, FL + 3 + GAP - 4 - 3);

        // Asynchronous reset during bit 3 of FF on lane 2
        send(8'hFF, 2'd2);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", int'({ser, s0, s1, frame, frame_done}), 0);
        q.delete();
        #3;
        rst_n = 1'b1;
        #1;
        chk("ready_after_midreset", int'(din_ready), 1);
        step();
        send(8'h3C, 2'd0);

        // din_valid held high with din changing every cycle
        wait_ready(n);
        din_valid = 1'b1;
        lane      = 2'd1;
        for (int c = 0; c <= 2 * P; c++) begin
            v   = 8'(c * 7 + 3);
            din = v;
            if (c % P == 0) begin
                push_frame(v, lane, -1, 0);
                lane = lane + 2'd1;
            end
            step();
        end
        din_valid = 1'b0;

        wait_ready(n);
        n = 0;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        step();
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_dispatch
`default_nettype wire

// File: doc/demux_dispatch.md
# demux_dispatch

Upstream driver for the 1:4 NAND-level demultiplexer stage. Accepts parallel bytes over a valid/ready handshake and serializes each byte LSB-first onto the demux data line `i`. It drives the demux select lines `s1:s0` with a round-robin lane number that is held stable for the whole frame, so consecutive bytes land on lanes 0, 1, 2, 3, 0, …

## Interface
- `DATA_W`, 8: byte width; number of data bits shifted per frame.
- `GAP_CYC`, 1: idle cycles after each frame with `i`=0 before the next byte is accepted; range 1–15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  `DATA_W`  byte to dispatch.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept a byte this cycle.
- `en`  in  1  shift enable; low freezes the frame in place.
- `i`  out  1  serial data into the demux.
- `s0`  out  1  lane select LSB.
- `s1`  out  1  lane select MSB.
- `frame`  out  1  high while a data/parity bit is being driven on `i`.
- `frame_done`  out  1  one-cycle pulse on the last bit of a frame.

## Operation
- The FSM has three states:
  - IDLE:
    - `din_ready`=1, `i`=0, `frame`=0.
    - On `din_valid & din_ready`: latch `din` into the shift register, latch the lane counter into the `s1:s0` register, load the bit counter with 0, go to SHIFT.
  - SHIFT:
    - `i` = shreg[0]; `frame`=1; `din_ready`=0.
    - On each cycle with `en`=1: shift right and increment the bit counter.
    - When the counter reaches FRAME_LEN-1 with `en`=1: assert `frame_done` and go to GAP.
  - GAP:
    - `i`=0, `frame`=0.
    - A counter counts `GAP_CYC` cycles, ignoring `en`.
    - On the final gap cycle, increment the lane counter (mod 4, 3→0) and go to IDLE.
- FRAME_LEN = `DATA_W` (+1 with parity, see Configuration).
- `s1:s0` change only on byte acceptance; they are constant through SHIFT and GAP and hold their last value in IDLE.
- In SHIFT with `en`=0: `i`, `s1:s0`, the bit counter and `frame` hold; `frame_done` stays 0. `en` has no effect in IDLE or GAP.
- `din_valid` while not ready is ignored; `din` is not sampled.
- Reset asserted (asynchronously) at any time:
  - State goes to IDLE.
  - All outputs go to 0 (`i`, `s0`, `s1`, `frame`, `frame_done`), except `din_ready`, which goes to 1 once reset is released.
  - The lane counter, bit counter and shift register are cleared; any partial byte is discarded.

## Timing
- A byte accepted at edge T puts bit0 on `i` in cycle T+1.
- Bit k appears in cycle T+1+k (no stalls).
- `frame_done` is asserted in the cycle of the last bit (T+FRAME_LEN).
- GAP occupies cycles T+FRAME_LEN+1 … T+FRAME_LEN+`GAP_CYC`.
- `din_ready` rises in cycle T+FRAME_LEN+`GAP_CYC`+1.
- Maximum throughput is one byte per FRAME_LEN+`GAP_CYC`+1 cycles; each `en`=0 cycle in SHIFT adds one cycle.
- All outputs are registered, with no combinational path from inputs to outputs. The exception is `din_ready`, which is decoded from the state only.

## Configuration
- `DEMUX_DISPATCH_PARITY_EN` defined:
  - Frames carry an extra bit after the MSB: the even-parity bit, XOR of all `DATA_W` bits.
  - FRAME_LEN = `DATA_W`+1.
  - `frame_done` fires on the parity bit.
- Undefined: no parity bit; FRAME_LEN = `DATA_W`.

## Structure
- Package `demux_dispatch_pkg`: FSM state enum (IDLE, SHIFT, GAP), lane-count constant 4, default `DATA_W`/`GAP_CYC` constants.
- Sub-module `rr_lane_ctr`: 2-bit round-robin lane counter with async active-low clear and increment strobe. It is instantiated once.

## Test plan
- Reset release, then `din`=0xA5 with `din_valid`=1 (no parity) → `i` = 1,0,1,0,0,1,0,1 over 8 cycles; `s1:s0`=00 throughout; `frame_done` on cycle 8; `din_ready` back after 1 gap cycle.
- Four back-to-back bytes 0x01, 0x02, 0x04, 0x08, then a fifth byte → lanes 00, 01, 10, 11, then wrap to 00; a single 1 appears at bit positions 0, 1, 2, 3 respectively.
- `en`=0 for 3 cycles during bit 4 of 0xF0 → `i`=1 held for 4 cycles; total frame length 11 cycles; `s1:s0` unchanged.
- `rst_n` pulsed low mid-frame (bit 3 of 0xFF on lane 2) → all outputs 0 immediately; next byte goes to lane 0 starting at bit0.
- With `DEMUX_DISPATCH_PARITY_EN` defined, `din`=0x01 → 9 bits 1,0,0,0,0,0,0,0,1; `frame_done` on bit 9. With `din`=0xA5 → parity bit 0.
- `din_valid` held high continuously with a changing `din` → only the values present in the cycles where `din_ready`=1 are serialized.
